// File: rtl/keyboard_pkg.sv
// keyboard_pkg: scan codes, note count, handshake states and code-to-note lookup
package keyboard_pkg;
  localparam int NUM_NOTES = 13;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_E      = 8'h24;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_F      = 8'h2B;
  localparam logic [7:0] SC_T      = 8'h2C;
  localparam logic [7:0] SC_G      = 8'h34;
  localparam logic [7:0] SC_Y      = 8'h35;
  localparam logic [7:0] SC_H      = 8'h33;
  localparam logic [7:0] SC_U      = 8'h3C;
  localparam logic [7:0] SC_J      = 8'h3B;
  localparam logic [7:0] SC_K      = 8'h42;
  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_LOW} hs_state_t;

  // Returns {hit, note index}; hit is 0 for any byte outside the 13-key map.
  function automatic logic [4:0] note_lookup(input logic [7:0] code);
    case (code)
      SC_A:    return {1'b1, 4'd0};
      SC_W:    return {1'b1, 4'd1};
      SC_S:    return {1'b1, 4'd2};
      SC_E:    return {1'b1, 4'd3};
      SC_D:    return {1'b1, 4'd4};
      SC_F:    return {1'b1, 4'd5};
      SC_T:    return {1'b1, 4'd6};
      SC_G:    return {1'b1, 4'd7};
      SC_Y:    return {1'b1, 4'd8};
      SC_H:    return {1'b1, 4'd9};
      SC_U:    return {1'b1, 4'd10};
      SC_J:    return {1'b1, 4'd11};
      SC_K:    return {1'b1, 4'd12};
      default: return 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/keyboard_sync_ff.sv
// keyboard_sync_ff: multi-stage flop synchroniser for the driver's scan_ready flag
module keyboard_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock50,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sr;
  // shift the asynchronous flag through the chain
  always_ff @(posedge clock50)
    if (!reset) sr <= '0;
    else sr <= {sr[SYNC_STAGES-2:0], d};
  assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/keyboard_note_decoder.sv
// keyboard_note_decoder: PS/2 set-2 byte handshake and parser to note events; OCTAVE_KEYS_EN adds Z/X octave keys
module keyboard_note_decoder
  import keyboard_pkg::*;
#(
  parameter int READ_HOLD    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int WAIT_TIMEOUT = 1_000_000
) (
  input  logic                 clock50,
  input  logic                 reset,
  input  logic                 scan_ready,
  input  logic [7:0]           scan_code,
  output logic                 read,
  output logic                 note_event,
  output logic                 note_on,
  output logic [3:0]           note_index,
  output logic [NUM_NOTES-1:0] note_held,
  output logic [1:0]           octave
);
  hs_state_t   state_q, state_d;
  logic [31:0] cnt;
  logic [7:0]  byte_q;
  logic        rdy_s, parse_v, ext_flag, brk_flag, hit;
  logic [3:0]  idx;

  keyboard_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock50(clock50),
    .reset(reset),
    .d(scan_ready),
    .q(rdy_s)
  );

  assign read = state_q == ACK;
  assign {hit, idx} = note_lookup(byte_q);

  // handshake next state: a new byte is only taken after rdy_s drops or the wait times out
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = rdy_s ? CAPTURE : IDLE;
      CAPTURE:  state_d = ACK;
      ACK:      state_d = (cnt == READ_HOLD - 1) ? WAIT_LOW : ACK;
      WAIT_LOW: state_d = (!rdy_s || cnt == WAIT_TIMEOUT - 1) ? IDLE : WAIT_LOW;
      default:  state_d = IDLE;
    endcase
  end

  // handshake state, per-state cycle counter, byte latch and parse strobe
  always_ff @(posedge clock50)
    if (!reset) begin
      state_q <= IDLE;
      cnt     <= '0;
      byte_q  <= '0;
      parse_v <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= (state_d != state_q) ? '0 : cnt + 32'd1;
      byte_q  <= (state_q == CAPTURE) ? scan_code : byte_q;
      parse_v <= state_q == CAPTURE;
    end

  // prefix tracking and note make/break events; brk_flag equal to the held bit means a real transition
  always_ff @(posedge clock50)
    if (!reset) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      note_event <= 1'b0;
      note_on    <= 1'b0;
      note_index <= '0;
      note_held  <= '0;
    end else begin
      note_event <= 1'b0;
      if (parse_v) begin
        if (byte_q == SC_EXT) ext_flag <= 1'b1;
        else if (byte_q == SC_BRK) brk_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (!ext_flag && hit && brk_flag == note_held[idx]) begin
            note_event     <= 1'b1;
            note_on        <= !brk_flag;
            note_index     <= idx;
            note_held[idx] <= !brk_flag;
          end
        end
      end
    end

`ifdef OCTAVE_KEYS_EN
  logic [1:0] oct_q, oct_held;
  // Z/X step the octave on fresh makes only, saturating at 0 and 3
  always_ff @(posedge clock50)
    if (!reset) begin
      oct_q    <= 2'd1;
      oct_held <= '0;
    end else if (parse_v && !ext_flag && byte_q == SC_OCT_DN) begin
      oct_held[0] <= !brk_flag;
      if (!brk_flag && !oct_held[0] && oct_q != 2'd0) oct_q <= oct_q - 2'd1;
    end else if (parse_v && !ext_flag && byte_q == SC_OCT_UP) begin
      oct_held[1] <= !brk_flag;
      if (!brk_flag && !oct_held[1] && oct_q != 2'd3) oct_q <= oct_q + 2'd1;
    end
  assign octave = oct_q;
`else
  assign octave = 2'd1;
`endif
endmodule

// File: tb/tb_keyboard_note_decoder.sv
// tb_keyboard_note_decoder: directed PS/2 byte sequences against hand-computed note events
module tb_keyboard_note_decoder;
  localparam int READ_HOLD    = 4;
  localparam int SYNC_STAGES  = 2;
  localparam int WAIT_TIMEOUT = 40;

  logic        clock50 = 1'b0;
  logic        reset = 1'b0;
  logic        scan_ready = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        read, note_event, note_on;
  logic [3:0]  note_index;
  logic [12:0] note_held;
  logic [1:0]  octave;
  int          errors = 0;
  int          checks = 0;

  keyboard_note_decoder #(
    .READ_HOLD(READ_HOLD),
    .SYNC_STAGES(SYNC_STAGES),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clock50(clock50),
    .reset(reset),
    .scan_ready(scan_ready),
    .scan_code(scan_code),
    .read(read),
    .note_event(note_event),
    .note_on(note_on),
    .note_index(note_index),
    .note_held(note_held),
    .octave(octave)
  );

  always #10 clock50 = ~clock50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver model: present a byte, drop scan_ready once read is seen, then observe the ack and any event
  task automatic send(input logic [7:0] code, input int exp_ev, input logic exp_on,
                      input logic [3:0] exp_idx, input logic [12:0] exp_held);
    int wait_n, rlen, evn, ev_rel;
    logic ev_on;
    logic [3:0] ev_idx;
    scan_code = code;
    scan_ready = 1'b1;
    wait_n = 0;
    do begin
      @(negedge clock50);
      wait_n++;
    end while (!read && wait_n < 20);
    check($sformatf("%02h read_seen", code), 32'(read), 32'd1);
    scan_ready = 1'b0;
    rlen = 0;
    evn = 0;
    ev_rel = -1;
    ev_on = 1'b0;
    ev_idx = '0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clock50);
      if (read) rlen++;
      if (note_event) begin
        evn++;
        ev_rel = k;
        ev_on = note_on;
        ev_idx = note_index;
      end
    end
    check($sformatf("%02h read_len", code), rlen, READ_HOLD);
    check($sformatf("%02h ev_count", code), evn, exp_ev);
    if (exp_ev > 0) begin
      check($sformatf("%02h ev_latency", code), ev_rel, 1);
      check($sformatf("%02h ev_on", code), 32'(ev_on), 32'(exp_on));
      check($sformatf("%02h ev_index", code), 32'(ev_idx), 32'(exp_idx));
    end
    check($sformatf("%02h held", code), 32'(note_held), 32'(exp_held));
  endtask

  initial begin
    int rise [3];
    int n, cyc, evs, wait_n;
    logic prev;
    repeat (3) @(negedge clock50);
    check("rst read", 32'(read), 32'd0);
    check("rst note_event", 32'(note_event), 32'd0);
    check("rst note_on", 32'(note_on), 32'd0);
    check("rst note_index", 32'(note_index), 32'd0);
    check("rst note_held", 32'(note_held), 32'd0);
    check("rst octave", 32'(octave), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clock50);

    send(8'h1C, 1, 1'b1, 4'd0, 13'h0001);
    send(8'h1C, 0, 1'b0, 4'd0, 13'h0001);
    send(8'h1C, 0, 1'b0, 4'd0, 13'h0001);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h0001);
    send(8'h1C, 1, 1'b0, 4'd0, 13'h0000);

    send(8'hE0, 0, 1'b0, 4'd0, 13'h0000);
    send(8'h1C, 0, 1'b0, 4'd0, 13'h0000);
    send(8'h42, 1, 1'b1, 4'd12, 13'h1000);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1000);
    send(8'h42, 1, 1'b0, 4'd12, 13'h0000);

    send(8'h1D, 1, 1'b1, 4'd1, 13'h0002);
    send(8'h42, 1, 1'b1, 4'd12, 13'h1002);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1002);
    send(8'h1D, 1, 1'b0, 4'd1, 13'h1000);
    send(8'h3B, 1, 1'b1, 4'd11, 13'h1800);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1800);
    send(8'h1C, 0, 1'b0, 4'd0, 13'h1800);
    send(8'hAA, 0, 1'b0, 4'd0, 13'h1800);
    send(8'hFA, 0, 1'b0, 4'd0, 13'h1800);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1800);
    send(8'h3B, 1, 1'b0, 4'd11, 13'h1000);

`ifdef OCTAVE_KEYS_EN
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000); check("oct up1", 32'(octave), 32'd2);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000); check("oct repeat", 32'(octave), 32'd2);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1000);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000); check("oct brk", 32'(octave), 32'd2);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000); check("oct up2", 32'(octave), 32'd3);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1000);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000); check("oct sat3", 32'(octave), 32'd3);
    send(8'hF0, 0, 1'b0, 4'd0, 13'h1000);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000);
    for (int i = 0; i < 4; i++) begin
      send(8'h1A, 0, 1'b0, 4'd0, 13'h1000);
      send(8'hF0, 0, 1'b0, 4'd0, 13'h1000);
      send(8'h1A, 0, 1'b0, 4'd0, 13'h1000);
      check($sformatf("oct dn%0d", i), 32'(octave), (i < 3) ? 32'(2 - i) : 32'd0);
    end
`else
    send(8'h1A, 0, 1'b0, 4'd0, 13'h1000);
    send(8'h22, 0, 1'b0, 4'd0, 13'h1000);
    check("oct const", 32'(octave), 32'd1);
`endif

    scan_code = 8'hAA;
    scan_ready = 1'b1;
    rise = '{0, 0, 0};
    n = 0;
    cyc = 0;
    evs = 0;
    prev = 1'b0;
    while (n < 3 && cyc < 400) begin
      @(negedge clock50);
      cyc++;
      if (read && !prev) begin
        rise[n] = cyc;
        n++;
      end
      prev = read;
      if (note_event) evs++;
    end
    check("to rises", n, 3);
    check("to period1", rise[1] - rise[0], 2 + READ_HOLD + WAIT_TIMEOUT);
    check("to period2", rise[2] - rise[1], 2 + READ_HOLD + WAIT_TIMEOUT);
    check("to events", evs, 0);
    scan_ready = 1'b0;
    repeat (WAIT_TIMEOUT + 20) @(negedge clock50);

    scan_code = 8'h1C;
    scan_ready = 1'b1;
    wait_n = 0;
    do begin
      @(negedge clock50);
      wait_n++;
    end while (!read && wait_n < 20);
    check("rack read_seen", 32'(read), 32'd1);
    check("rack held_before", 32'(note_held), 32'h1000);
    reset = 1'b0;
    @(negedge clock50);
    check("rack read", 32'(read), 32'd0);
    check("rack held", 32'(note_held), 32'd0);
    check("rack event", 32'(note_event), 32'd0);
    scan_ready = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clock50);
    check("rack octave", 32'(octave), 32'd1);
    send(8'h24, 1, 1'b1, 4'd3, 13'h0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keyboard_note_decoder.md
Name: keyboard_note_decoder

Overview:
- Sits directly downstream of the PS/2 inner driver and upstream of the tone generator.
- Consumes the driver's scan_code/scan_ready pair and drives the driver's read handshake.
- Parses the PS/2 set-2 make, break (F0) and extended (E0) sequences, and maps 13 keys (A W S E D F T G Y H U J K) to note indices 0..12.
- Outputs one-cycle note on/off events plus a held-note bitmap.

Parameters:
- READ_HOLD, 4, clock50 cycles that read stays high per acknowledged byte (min 2).
- SYNC_STAGES, 2, flip-flops in the scan_ready synchroniser (min 2).
- WAIT_TIMEOUT, 1_000_000, cycles to wait for synced scan_ready to fall before forcing return to IDLE (20 ms).

Ports:
- clock50  input  1  50 MHz system clock
- reset  input  1  synchronous, active-low
- scan_ready  input  1  byte-available flag from driver; asynchronous to clock50
- scan_code  input  8  byte from driver; stable while scan_ready high
- read  output  1  acknowledge to driver; high clears driver scan_ready
- note_event  output  1  one-cycle pulse; note_index/note_on valid
- note_on  output  1  1 = key pressed, 0 = released; qualified by note_event
- note_index  output  4  0..12; qualified by note_event
- note_held  output  13  bit n high while note n is held
- octave  output  2  current octave select

Behaviour:
- Reset (reset==0 at posedge clock50): all outputs 0 except octave=1; FSM to IDLE; prefix flags, counters and synchroniser cleared. Reset mid-handshake drops read the next cycle.
- scan_ready passes through SYNC_STAGES flops → rdy_s. scan_code is sampled only in CAPTURE, at least SYNC_STAGES cycles after the rising edge, so no separate sync is needed.
- Handshake FSM:
  - IDLE: rdy_s==1 → CAPTURE.
  - CAPTURE (1 cycle): latch scan_code into byte_q → ACK.
  - ACK: read=1 for READ_HOLD cycles → WAIT_LOW.
  - WAIT_LOW: read=0. rdy_s==0 → IDLE. Otherwise, if the timeout counter reaches WAIT_TIMEOUT → IDLE.
  - A new byte is never captured until rdy_s has been seen low or the timeout has fired.
- Parser runs in the cycle after CAPTURE, on byte_q:
  - E0: set ext_flag; no event.
  - F0: set brk_flag; no event.
  - Other byte with ext_flag=1: ignored (extended keys unmapped). Clear both flags.
  - Other byte that maps to note n:
    - brk_flag=0 and note_held[n]=0: note_event=1, note_on=1, note_index=n, set held bit.
    - brk_flag=0 and note_held[n]=1 (typematic repeat): no event.
    - brk_flag=1 and held bit set: note_event=1, note_on=0, clear held bit.
    - brk_flag=1 and held bit clear: no event.
    - Clear both flags in all four cases.
  - Unmapped byte: no event; clear flags. This includes AA (self-test pass) and FA (ack).
- Key map (code→n): 1C→0, 1D→1, 1B→2, 24→3, 23→4, 2B→5, 2C→6, 34→7, 35→8, 33→9, 3C→10, 3B→11, 42→12.
- Event latency: note_event is asserted exactly 2 cycles after the CAPTURE cycle. At most one event per byte. Simultaneous keys are handled as sequential bytes; note_held may hold any combination.
- note_held updates in the same cycle as note_event.

Optional Feature:
- Macro OCTAVE_KEYS_EN.
- Defined: make of Z (1A) decrements octave and make of X (22) increments it, saturating at 0 and 3. Break codes and typematic repeats of Z/X are ignored (Z/X tracked in a 2-bit held register). No note_event is generated for Z/X.
- Undefined: octave constant 1; 1A/22 are unmapped bytes.

Decomposition:
- Package keyboard_pkg:
  - scan-code constants (SC_EXT=8'hE0, SC_BRK=8'hF0, the 13 note codes, SC_OCT_DN=8'h1A, SC_OCT_UP=8'h22);
  - NUM_NOTES=13;
  - handshake state enum (IDLE, CAPTURE, ACK, WAIT_LOW);
  - code→note lookup function returning {hit, index}.
- Sub-module keyboard_sync_ff: parameterised SYNC_STAGES synchroniser for scan_ready.

Test Plan:
- Driver model presents 1C with scan_ready, clearing scan_ready on read → read high exactly READ_HOLD cycles. note_event with note_on=1, note_index=0 occurs 2 cycles after CAPTURE. note_held=13'h0001.
- Sequence 1C, 1C, 1C, then F0 1C → exactly one on-event and one off-event (index 0); note_held=0 at end.
- E0 1C then 42 → no event for the E0-prefixed byte; the 42 gives on-event with index 12.
- Press 1D and 42 without release, then F0 1D → note_held goes 13'h0002, then 13'h1002, then 13'h1000; the release gives off-event with index 1.
- scan_ready held high, never cleared → FSM returns to IDLE after WAIT_TIMEOUT cycles. Exactly one capture per timeout period; no hang.
- reset pulled low during ACK → read=0 and note_held=0 on the next cycle. With OCTAVE_KEYS_EN: 22 ×3 → octave=3 and stays saturated; 1A ×4 → octave=0.
